// File: rtl/poly_voice_mixer.sv
// N-channel voice mixer: per-channel gain, one time-shared MAC,
// averaging or saturating output, sticky clip flag on the synth bus.
module poly_voice_mixer #(
    parameter int          WAVE_DEPTH   = 8,
    parameter int          NUM_CHANNELS = 4,
    parameter int          GAIN_DEPTH   = 8,
    parameter logic [15:0] ADDR         = 16'h0020
) (
    input  logic                               Clock,
    input  logic                               Reset,
    input  logic [15:0]                        BusAddress,
    inout  wire  [7:0]                         BusData,
    input  logic                               BusReadWrite,
    input  logic                               BusClock,
    input  logic [NUM_CHANNELS*WAVE_DEPTH-1:0] SampleIn,
    input  logic                               SampleValid,
    output logic                               SampleReady,
    output logic [WAVE_DEPTH-1:0]              MixOut,
    output logic                               MixValid,
    output logic                               Busy
);

    localparam int LOGN = $clog2(NUM_CHANNELS);
    localparam int IW   = (LOGN > 0) ? LOGN : 1;
    localparam int PW   = WAVE_DEPTH + GAIN_DEPTH;
    localparam int AW   = PW + LOGN;

    localparam logic [GAIN_DEPTH-1:0] UNITY = {1'b1, {(GAIN_DEPTH-1){1'b0}}};
    localparam logic [AW-1:0]         OMAX  = AW'((1 << WAVE_DEPTH) - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    state_t state, nstate;

    logic [GAIN_DEPTH-1:0] gain  [NUM_CHANNELS];
    logic [GAIN_DEPTH-1:0] gsnap [NUM_CHANNELS];
    logic [WAVE_DEPTH-1:0] samp  [NUM_CHANNELS];
    logic [1:0]            ctrl;
    logic                  clip;
    logic                  sat;
    logic [AW-1:0]         acc;
    logic [IW-1:0]         idx;

    logic [2:0]            bsync;
    logic                  bedge;
    logic                  wr;
    logic [15:0]           off;
    logic                  hit;
    logic [7:0]            rdata;

    logic                  accept;
    logic [PW-1:0]         prod;
    logic [AW-1:0]         scaled;
    logic [WAVE_DEPTH-1:0] avg;
    logic                  over;
    logic [WAVE_DEPTH-1:0] mix;
    logic                  clip_set;

    // Bus side: BusClock is asynchronous, so only its synchronised edge writes
    assign off   = BusAddress - ADDR;
    assign hit   = off < 16'(NUM_CHANNELS + 2);
    assign bedge = bsync[1] & ~bsync[2];
    assign wr    = bedge & ~BusReadWrite & hit;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            bsync <= '0;
        end else begin
            bsync <= {bsync[1:0], BusClock};
        end
    end

    always_comb begin
        rdata = '0;
        if (off < 16'(NUM_CHANNELS)) begin
            rdata = 8'(gain[off[IW-1:0]]);
        end else if (off == 16'(NUM_CHANNELS)) begin
            rdata = {6'b0, ctrl};
        end else if (off == 16'(NUM_CHANNELS + 1)) begin
            rdata = {6'b0, clip, Busy};
        end
    end

    assign BusData = (BusReadWrite && hit && !Reset) ? rdata : 8'bz;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                gain[i] <= UNITY;
            end
            ctrl <= '0;
            clip <= 1'b0;
        end else begin
            if (wr) begin
                if (off < 16'(NUM_CHANNELS)) begin
                    gain[off[IW-1:0]] <= BusData[GAIN_DEPTH-1:0];
                end else if (off == 16'(NUM_CHANNELS)) begin
                    ctrl <= BusData[1:0];
                end else begin
                    clip <= 1'b0;
                end
            end
            // A clamp in the same cycle as a STATUS write must not be lost
            if (clip_set) begin
                clip <= 1'b1;
            end
        end
    end

    // Mix datapath
    assign accept      = (state == IDLE) & SampleValid & ctrl[0];
    assign SampleReady = (state == IDLE) & ctrl[0];
    assign Busy        = (state != IDLE);

    assign prod     = PW'(samp[idx]) * PW'(gsnap[idx]);
    assign scaled   = acc >> (GAIN_DEPTH - 1);
    assign avg      = WAVE_DEPTH'(scaled >> LOGN);
    assign over     = scaled > OMAX;
    assign mix      = sat ? (over ? '1 : scaled[WAVE_DEPTH-1:0]) : avg;
    assign clip_set = (state == OUTPUT) & sat & over;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (accept) nstate = ACCUM;
            ACCUM:   if (idx == IW'(NUM_CHANNELS - 1)) nstate = OUTPUT;
            OUTPUT:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                samp[i]  <= '0;
                gsnap[i] <= '0;
            end
            acc      <= '0;
            idx      <= '0;
            sat      <= 1'b0;
            MixOut   <= '0;
            MixValid <= 1'b0;
        end else begin
            MixValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            samp[i]  <= SampleIn[i*WAVE_DEPTH +: WAVE_DEPTH];
                            gsnap[i] <= gain[i];
                        end
                        acc <= '0;
                        idx <= '0;
                        sat <= ctrl[1];
                    end
                end
                ACCUM: begin
                    acc <= acc + AW'(prod);
                    idx <= idx + 1'b1;
                end
                OUTPUT: begin
                    MixOut   <= mix;
                    MixValid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Directed and randomized bench for poly_voice_mixer against an
// arithmetic reference model of gains, mode and clip flag.
module tb_poly_voice_mixer;

    localparam int N = 4;
    localparam int W = 8;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [15:0]   BusAddress;
    logic          BusReadWrite;
    logic          BusClock;
    logic [N*W-1:0] SampleIn;
    logic          SampleValid;
    wire           SampleReady;
    wire  [W-1:0]  MixOut;
    wire           MixValid;
    wire           Busy;
    wire  [7:0]    BusData;

    logic [7:0]    drv;
    logic          oe;

    assign BusData = oe ? drv : 8'bz;

    poly_voice_mixer dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .BusAddress   (BusAddress),
        .BusData      (BusData),
        .BusReadWrite (BusReadWrite),
        .BusClock     (BusClock),
        .SampleIn     (SampleIn),
        .SampleValid  (SampleValid),
        .SampleReady  (SampleReady),
        .MixOut       (MixOut),
        .MixValid     (MixValid),
        .Busy         (Busy)
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;
    int mg[N];
    int mctrl;
    int mclip;
    int wt;
    int pulses;
    logic [7:0] rd;
    logic [31:0] rs;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mg[i] = 'h80;
        mctrl = 0;
        mclip = 0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        int o;
        @(negedge Clock);
        BusAddress   = a;
        drv          = d;
        oe           = 1'b1;
        BusReadWrite = 1'b0;
        BusClock     = 1'b1;
        repeat (5) @(negedge Clock);
        BusClock = 1'b0;
        repeat (2) @(negedge Clock);
        oe = 1'b0;
        o = int'(a) - 'h20;
        if (o >= 0 && o < N) mg[o] = d;
        else if (o == N) mctrl = d & 3;
        else if (o == N + 1) mclip = 0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        BusAddress   = a;
        BusReadWrite = 1'b1;
        #1;
        d = BusData;
        BusReadWrite = 1'b0;
        #1;
    endtask

    task automatic run_mix(input string tag, input logic [31:0] s);
        int sum, sc, exp, cyc, t;
        bit got;
        sum = 0;
        for (int i = 0; i < N; i++) sum += int'(s[i*W +: W]) * mg[i];
        sc = sum >> 7;
        if (mctrl[1]) begin
            exp = (sc > 255) ? 255 : sc;
            if (sc > 255) mclip = 1;
        end else begin
            exp = (sc >> 2) & 255;
        end
        t = 0;
        @(negedge Clock);
        while (!SampleReady && t < 20) begin
            @(negedge Clock);
            t++;
        end
        check({tag, "_ready"}, SampleReady, 1);
        SampleIn    = s;
        SampleValid = 1'b1;
        @(posedge Clock);
        #1;
        SampleValid = 1'b0;
        check({tag, "_busy"}, Busy, 1);
        cyc = 0;
        got = 0;
        while (cyc < 20 && !got) begin
            @(posedge Clock);
            #1;
            cyc++;
            if (MixValid) got = 1;
        end
        check({tag, "_lat"}, cyc, N + 1);
        check({tag, "_out"}, MixOut, exp);
        @(posedge Clock);
        #1;
        check({tag, "_pulse"}, MixValid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset        = 1'b1;
        BusAddress   = '0;
        BusReadWrite = 1'b0;
        BusClock     = 1'b0;
        SampleIn     = '0;
        SampleValid  = 1'b0;
        drv          = '0;
        oe           = 1'b0;
        model_reset();
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);

        // reset state
        for (int i = 0; i < N + 2; i++) begin
            bus_read(16'(16'h20 + i), rd);
            check($sformatf("rst_reg%0d", i), rd, (i < N) ? 'h80 : 'h00);
        end
        check("rst_ready", SampleReady, 0);
        check("rst_mixout", MixOut, 0);
        check("rst_busy", Busy, 0);

        // averaging, full scale
        bus_write(16'h24, 8'h01);
        run_mix("avg_ff", 32'hFFFF_FFFF);

        // saturating with clip, then clear
        bus_write(16'h24, 8'h03);
        run_mix("sat_40", 32'h4040_4040);
        bus_read(16'h25, rd);
        check("clip_set", rd, 8'h02);
        bus_write(16'h25, 8'h00);
        bus_read(16'h25, rd);
        check("clip_clr", rd, 8'h00);
        run_mix("sat_20", 32'h2020_2020);
        bus_read(16'h25, rd);
        check("clip_stay0", rd, 8'h00);

        // single-channel gain
        bus_write(16'h21, 8'h00);
        bus_write(16'h22, 8'h00);
        bus_write(16'h23, 8'h00);
        bus_write(16'h20, 8'h40);
        run_mix("gain40", 32'hFFFF_FFC8);
        bus_write(16'h20, 8'hFF);
        run_mix("gainff", 32'hFFFF_FFC8);
        bus_read(16'h25, rd);
        check("clip_gain", rd, 8'h02);
        bus_write(16'h25, 8'h00);

        // gain write during ACCUM only affects the next set
        for (int i = 0; i < N; i++) bus_write(16'(16'h20 + i), 8'h80);
        fork
            run_mix("snap_a", 32'h1010_1010);
            begin
                wt = 0;
                while (!Busy && wt < 30) begin
                    @(negedge Clock);
                    wt++;
                end
                bus_write(16'h20, 8'h00);
            end
        join
        bus_read(16'h20, rd);
        check("snap_gain", rd, 8'h00);
        run_mix("snap_b", 32'h1010_1010);

        // reset in the middle of ACCUM
        @(negedge Clock);
        SampleIn    = 32'h5555_5555;
        SampleValid = 1'b1;
        @(posedge Clock);
        #1;
        SampleValid = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        #1;
        check("rmid_valid", MixValid, 0);
        check("rmid_out", MixOut, 0);
        check("rmid_busy", Busy, 0);
        model_reset();
        repeat (2) @(negedge Clock);
        Reset  = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(posedge Clock);
            #1;
            if (MixValid) pulses++;
        end
        check("rmid_nopulse", pulses, 0);
        bus_read(16'h20, rd);
        check("rmid_gain0", rd, 8'h80);
        bus_write(16'h24, 8'h01);
        run_mix("rmid_fresh", 32'h8040_2010);

        // randomized mixes
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0)
                    bus_write(16'(16'h20 + i), 8'($urandom));
            end
            bus_write(16'h24, ($urandom_range(0, 1) != 0) ? 8'h03 : 8'h01);
            rs = $urandom;
            run_mix($sformatf("rnd%0d", k), rs);
            bus_read(16'h25, rd);
            check($sformatf("rnd%0d_stat", k), rd, mclip ? 8'h02 : 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
